// File: rtl/desc_slot_scheduler_if.sv
// Descriptor in/out channels and slot-release strobe shared between the
// scheduler (slave) and its environment (master).
interface desc_slot_scheduler_if #(
    parameter int DESC_WIDTH    = 64,
    parameter int CORE_ID_WIDTH = 3
);
    logic [DESC_WIDTH-1:0]    s_desc;
    logic                     s_desc_valid;
    logic                     s_desc_ready;
    logic [DESC_WIDTH-1:0]    m_desc;
    logic [CORE_ID_WIDTH-1:0] m_desc_core;
    logic                     m_desc_valid;
    logic                     m_desc_ready;
    logic                     slot_release_valid;
    logic [CORE_ID_WIDTH-1:0] slot_release_core;

    modport slave (
        input  s_desc, s_desc_valid, m_desc_ready, slot_release_valid, slot_release_core,
        output s_desc_ready, m_desc, m_desc_core, m_desc_valid
    );

    modport master (
        output s_desc, s_desc_valid, m_desc_ready, slot_release_valid, slot_release_core,
        input  s_desc_ready, m_desc, m_desc_core, m_desc_valid
    );
endinterface

// File: rtl/desc_slot_scheduler.sv
// Credit-based round-robin dispatcher: each inbound descriptor goes to the next
// eligible core that still has a free packet slot, through a one-entry output stage.
module desc_slot_scheduler #(
    parameter int CORE_COUNT    = 8,
    parameter int CORE_ID_WIDTH = 3,
    parameter int SLOT_COUNT    = 16,
    parameter int DESC_WIDTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    desc_slot_scheduler_if.slave  bus,
    input  logic [CORE_COUNT-1:0] core_enable,
    input  logic [CORE_COUNT-1:0] core_reset,
    output logic [31:0]           stall_count,
    output logic                  release_overflow
);
    localparam int CW = $clog2(SLOT_COUNT + 1);
    localparam logic [CW-1:0] FULL_CREDIT = CW'(SLOT_COUNT);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t                   state_reg;
    logic [DESC_WIDTH-1:0]    m_desc_reg;
    logic [CORE_ID_WIDTH-1:0] m_desc_core_reg;
    logic                     m_desc_valid_reg;
    logic [CORE_ID_WIDTH-1:0] rr_ptr_reg;
    logic [31:0]              stall_count_reg;
    logic                     release_overflow_reg;
    logic [CW-1:0]            credit_reg [CORE_COUNT];

    logic [CORE_COUNT-1:0]    eligible;
    logic [CORE_COUNT-1:0]    take;
    logic [CORE_COUNT-1:0]    give;
    logic [CORE_COUNT-1:0]    overflow_hit;
    logic                     any_eligible;
    logic                     ready;
    logic                     accept;
    logic                     release_in_range;
    logic                     overflow_event;
    logic [CORE_ID_WIDTH-1:0] sel_core;

    generate
        for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_core
            assign eligible[gi] = core_enable[gi] && (credit_reg[gi] != '0) && !core_reset[gi];
            assign take[gi]     = accept && (sel_core == CORE_ID_WIDTH'(gi));
            assign give[gi]     = bus.slot_release_valid && (bus.slot_release_core == CORE_ID_WIDTH'(gi));
            // A release onto a full counter is an error unless a dispatch or core reset absorbs it.
            assign overflow_hit[gi] = give[gi] && !take[gi] && !core_reset[gi]
                                      && (credit_reg[gi] == FULL_CREDIT);
        end
    endgenerate

    assign any_eligible     = |eligible;
    assign ready            = rst_n && any_eligible && ((state_reg == ST_EMPTY) || bus.m_desc_ready);
    assign accept           = bus.s_desc_valid && ready;
    assign release_in_range = int'(bus.slot_release_core) < CORE_COUNT;
    assign overflow_event   = (|overflow_hit) || (bus.slot_release_valid && !release_in_range);

    // First eligible core at or after the round-robin pointer.
    always_comb begin
        logic found;
        int   idx;
        found    = 1'b0;
        idx      = 0;
        sel_core = '0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            idx = (int'(rr_ptr_reg) + k) % CORE_COUNT;
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                sel_core = CORE_ID_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORE_COUNT; i++) credit_reg[i] <= FULL_CREDIT;
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                if (core_reset[i])
                    credit_reg[i] <= FULL_CREDIT;
                else if (take[i] && !give[i])
                    credit_reg[i] <= credit_reg[i] - 1'b1;
                else if (give[i] && !take[i] && (credit_reg[i] != FULL_CREDIT))
                    credit_reg[i] <= credit_reg[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= ST_EMPTY;
            m_desc_reg           <= '0;
            m_desc_core_reg      <= '0;
            m_desc_valid_reg     <= 1'b0;
            rr_ptr_reg           <= '0;
            stall_count_reg      <= '0;
            release_overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY: if (accept) begin
                    state_reg        <= ST_FULL;
                    m_desc_valid_reg <= 1'b1;
                end
                ST_FULL: if (bus.m_desc_ready && !accept) begin
                    state_reg        <= ST_EMPTY;
                    m_desc_valid_reg <= 1'b0;
                end
                default: begin
                    state_reg        <= ST_EMPTY;
                    m_desc_valid_reg <= 1'b0;
                end
            endcase
            if (accept) begin
                m_desc_reg      <= bus.s_desc;
                m_desc_core_reg <= sel_core;
                rr_ptr_reg      <= (int'(sel_core) == CORE_COUNT - 1) ? '0 : sel_core + 1'b1;
            end
            if (bus.s_desc_valid && !any_eligible)
                stall_count_reg <= stall_count_reg + 32'd1;
            if (overflow_event)
                release_overflow_reg <= 1'b1;
        end
    end

    assign bus.s_desc_ready = ready;
    assign bus.m_desc       = m_desc_reg;
    assign bus.m_desc_core  = m_desc_core_reg;
    assign bus.m_desc_valid = m_desc_valid_reg;
    assign stall_count      = stall_count_reg;
    assign release_overflow = release_overflow_reg;
endmodule
